// File: rtl/cache_memory_arbiter.sv
// -----------------------------------------------------------------------------
// cache_memory_arbiter
//
// Lets the instruction-cache and data-cache miss controllers share one
// main-memory port. Only one transfer is in flight at a time. When both sides
// request in the same cycle, a round-robin pointer decides which side goes
// first, and the pointer flips after each such collision. A watchdog aborts any
// transfer that receives no mem_ready within TIMEOUT busy cycles.
//
// Ports
//   clk, reset            rising-edge clock; synchronous active-low reset
//   i_rd, i_addr          I-cache read request (held until i_ready)
//   i_rdata, i_ready      I-cache read data and one-cycle completion pulse
//   d_rd, d_wr            D-cache read / write-back request (held until d_ready)
//   d_addr, d_wdata       D-cache address and write data
//   d_rdata, d_ready      D-cache read data and one-cycle completion pulse
//   mem_rd, mem_wr        memory strobes, held for the whole transfer
//   mem_addr, mem_wdata   registered address and write data to memory
//   mem_rdata, mem_ready  memory read data and completion pulse
//   grant_d               1 when the current or most recent owner is the D-side
//   mem_timeout           sticky flag, set when the watchdog aborts a transfer
// -----------------------------------------------------------------------------
module cache_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rd,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_rd,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  grant_d,
  output logic                  mem_timeout
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q,     state_d;
  logic                  prefer_d_q,  prefer_d_d;
  logic                  grant_d_q,   grant_d_d;
  logic                  mem_rd_q,    mem_rd_d;
  logic                  mem_wr_q,    mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q,   i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;
  logic                  i_ready_q,   i_ready_d;
  logic                  d_ready_q,   d_ready_d;
  logic                  timeout_q,   timeout_d;
  logic [WD_W-1:0]       wd_q,        wd_d;

  logic i_req, d_req, pick_d;

  assign i_req  = i_rd;
  assign d_req  = d_rd | d_wr;
  // The D-side wins when it is alone, or when both sides collide and the
  // pointer currently favours it.
  assign pick_d = d_req & (~i_req | prefer_d_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred; blocking '=' is correct in
    // combinational logic.
    state_d     = state_q;
    prefer_d_d  = prefer_d_q;
    grant_d_d   = grant_d_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    timeout_d   = timeout_q;
    wd_d        = wd_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req | d_req) begin
          state_d   = ST_BUSY;
          grant_d_d = pick_d;
          wd_d      = '0;
          // The pointer only moves when there was a real contest.
          if (i_req & d_req) prefer_d_d = ~prefer_d_q;
          if (pick_d) begin
            // A simultaneous read and write from the D-side is a write-back.
            mem_wr_d    = d_wr;
            mem_rd_d    = ~d_wr;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_rd_d   = 1'b1;
            mem_wr_d   = 1'b0;
            mem_addr_d = i_addr;
          end
        end
      end

      ST_BUSY: begin
        if (mem_ready) begin
          state_d  = ST_RESP;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (grant_d_q) begin
            d_ready_d = 1'b1;
            if (mem_rd_q) d_rdata_d = mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (wd_q == WD_LAST) begin
          // Abort: release the memory and complete the owner with zero data.
          state_d   = ST_RESP;
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          timeout_d = 1'b1;
          if (grant_d_q) begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = '0;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      // One dead cycle lets the completed requester drop its request before
      // the arbiter samples requests again.
      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      prefer_d_q  <= 1'b1;
      grant_d_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples
      // the values from before this edge.
      state_q     <= state_d;
      prefer_d_q  <= prefer_d_d;
      grant_d_q   <= grant_d_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
    end
  end

  assign i_rdata     = i_rdata_q;
  assign i_ready     = i_ready_q;
  assign d_rdata     = d_rdata_q;
  assign d_ready     = d_ready_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign grant_d     = grant_d_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_cache_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_memory_arbiter
//
// Self-checking bench for cache_memory_arbiter. A transaction-level model keeps
// track of the round-robin preference, the expected contents of each rdata
// register and the sticky timeout flag. A memory responder answers each
// transfer after a configured latency and drives random mem_ready/mem_rdata
// noise whenever no strobe is active.
// -----------------------------------------------------------------------------
module tb_cache_memory_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_rd, d_rd, d_wr;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_rd, mem_wr, mem_ready, grant_d, mem_timeout;

  always #5 clk = ~clk;

  cache_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_d(grant_d), .mem_timeout(mem_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory responder: mem_ready is seen by the arbiter lat_cfg edges after the
  // strobe first appears. Outside a transfer it drives random noise.
  int            lat_cfg  = 1;
  logic [DW-1:0] data_cfg = '0;
  int            mem_cnt;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    mem_cnt   = 0;
    forever begin
      @(negedge clk);
      if (mem_rd | mem_wr) begin
        if (mem_cnt == lat_cfg - 1) begin
          mem_ready = 1'b1;
          mem_rdata = data_cfg;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        mem_cnt++;
      end else begin
        mem_cnt   = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Reference model state.
  bit            prefer_d_m;
  bit            timeout_m;
  logic [DW-1:0] i_rdata_m, d_rdata_m;

  task automatic model_reset();
    prefer_d_m = 1'b1;
    timeout_m  = 1'b0;
    i_rdata_m  = '0;
    d_rdata_m  = '0;
  endtask

  // Runs one transfer owned by side_d, starting from a cycle in which its
  // request is already applied and the arbiter is (or becomes) idle.
  task automatic serve(input bit side_d, input bit is_wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] dat);
    int cnt;
    int exp_wait;
    lat_cfg  = lat;
    data_cfg = dat;
    cnt = 0;
    while (!(mem_rd | mem_wr) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("grant_delay", 64'(cnt), 64'd1);
    check("mem_rd",  mem_rd,  !is_wr);
    check("mem_wr",  mem_wr,  is_wr);
    check("mem_addr", mem_addr, addr);
    if (is_wr) check("mem_wdata", mem_wdata, wdata);
    check("grant_d", grant_d, side_d);

    cnt = 0;
    while (!(i_ready | d_ready) && cnt < TO + 5) begin
      @(negedge clk);
      cnt++;
    end
    exp_wait = (lat <= TO) ? lat : TO;
    check("ready_delay", 64'(cnt), 64'(exp_wait));

    if (lat > TO) begin
      timeout_m = 1'b1;
      if (side_d) d_rdata_m = '0; else i_rdata_m = '0;
    end else if (!is_wr) begin
      if (side_d) d_rdata_m = dat; else i_rdata_m = dat;
    end

    check("i_ready", i_ready, !side_d);
    check("d_ready", d_ready, side_d);
    check("strobes_after_done", {mem_rd, mem_wr}, 2'b00);
    check("i_rdata", i_rdata, i_rdata_m);
    check("d_rdata", d_rdata, d_rdata_m);
    check("mem_timeout", mem_timeout, timeout_m);
    check("grant_d_hold", grant_d, side_d);

    if (side_d) begin
      d_rd = 1'b0;
      d_wr = 1'b0;
    end else begin
      i_rd = 1'b0;
    end
    @(negedge clk);
    check("ready_one_cycle", {i_ready, d_ready}, 2'b00);
    check("grant_d_idle", grant_d, side_d);
  endtask

  // Applies a set of simultaneous requests and predicts their service order.
  task automatic run_round(input bit ri, input bit dr, input bit dw,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [DW-1:0] dd, input int lat0, input logic [DW-1:0] dat0,
                           input int lat1, input logic [DW-1:0] dat1);
    bit dreq;
    bit collide;
    bit d_first;
    dreq = dr | dw;
    if (!ri && !dreq) begin
      @(negedge clk);
      check("idle_quiet", {mem_rd, mem_wr, i_ready, d_ready}, 4'b0000);
      return;
    end
    i_rd = ri; i_addr = ia;
    d_rd = dr; d_wr = dw; d_addr = da; d_wdata = dd;
    collide = ri && dreq;
    d_first = dreq && (!ri || prefer_d_m);
    if (collide) prefer_d_m = !prefer_d_m;
    if (d_first) serve(1'b1, dw, da, dd, lat0, dat0);
    else         serve(1'b0, 1'b0, ia, '0, lat0, dat0);
    if (collide) begin
      if (d_first) serve(1'b0, 1'b0, ia, '0, lat1, dat1);
      else         serve(1'b1, dw, da, dd, lat1, dat1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b0;
    i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    model_reset();

    // Reset held two cycles: every output must be low.
    repeat (2) @(negedge clk);
    check("rst_outputs", {i_ready, d_ready, mem_rd, mem_wr, grant_d, mem_timeout}, 6'b0);
    check("rst_data", {i_rdata, d_rdata, mem_addr, mem_wdata}, 128'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single I read with a 3-cycle memory.
    run_round(1, 0, 0, 32'h100, '0, '0, 3, 32'hDEADBEEF, 0, '0);
    // Collision after reset: D write goes first, then I; next collision I wins.
    run_round(1, 0, 1, 32'h300, 32'h200, 32'h12345678, 2, $urandom, 4, 32'hCAFEF00D);
    run_round(1, 1, 0, 32'h304, 32'h204, '0, 1, $urandom, 2, $urandom);
    // d_rd and d_wr together: a write; d_rdata keeps its value.
    run_round(0, 1, 1, '0, 32'h208, 32'hA5A5A5A5, 2, 32'h0BADBAD0, 0, '0);
    // Watchdog abort, then a good transfer keeps the sticky flag.
    run_round(0, 1, 0, '0, 32'h20C, '0, TO + 3, 32'h11111111, 0, '0);
    run_round(1, 0, 0, 32'h108, '0, '0, 2, 32'h22222222, 0, '0);
    // Latency boundaries around the watchdog limit.
    run_round(1, 0, 0, 32'h10C, '0, '0, TO, 32'h33333333, 0, '0);
    run_round(0, 1, 0, '0, 32'h210, '0, TO + 1, 32'h44444444, 0, '0);
    // Idle cycle with memory noise.
    run_round(0, 0, 0, '0, '0, '0, 0, '0, 0, '0);

    // Reset while BUSY: strobes drop, no ready pulse, state cleared.
    lat_cfg = TO + 3;
    i_rd = 1'b1; i_addr = 32'h400;
    cnt = 0;
    while (!mem_rd && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_busy_grant", 64'(cnt), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    i_rd  = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_busy_strobes", {mem_rd, mem_wr}, 2'b00);
    check("rst_busy_ready", {i_ready, d_ready}, 2'b00);
    check("rst_busy_timeout", mem_timeout, timeout_m);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", {mem_rd, mem_wr, i_ready, d_ready}, 4'b0000);
    end
    // Pointer must again favour the D-side after reset.
    run_round(1, 1, 0, 32'h500, 32'h600, '0, 2, $urandom, 3, $urandom);

    // Randomized traffic.
    for (int r = 0; r < 200; r++) begin
      run_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom,
                $urandom_range(1, TO + 2), $urandom,
                $urandom_range(1, TO + 2), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
